// File: rtl/alu_response_checker.sv
// Self-test checker beside the ALU: recomputes each operand vector's expected result, aligns it to the
// ALU's output latency, compares, counts and locates failures, and folds every response into a MISR.
module alu_response_checker #(
  parameter int unsigned      WIDTH       = 32,
  parameter int unsigned      LATENCY     = 1,
  parameter int unsigned      NUM_VECTORS = 100000,
  parameter int unsigned      CNT_W       = 17,
  parameter int unsigned      ERR_W       = 16,
  parameter logic [WIDTH-1:0] POLY        = WIDTH'(32'h04C11DB7)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       ctrl,
  input  logic [WIDTH-1:0] r,
  input  logic             zero,
  input  logic             ovf,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             mismatch,
  output logic [ERR_W-1:0] err_count,
  output logic             first_err_valid,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [WIDTH-1:0] signature
);

  localparam logic [CNT_W-1:0] NUM_VEC  = CNT_W'(NUM_VECTORS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VECTORS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic             vld;
    logic [WIDTH-1:0] r;
    logic             zero;
    logic             ovf;
    logic [CNT_W-1:0] idx;
  } pipe_ent_t;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] accepted_q, accepted_d;
  logic [CNT_W-1:0] compared_q, compared_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             fev_q, fev_d;
  logic [CNT_W-1:0] fei_q, fei_d;
  logic [WIDTH-1:0] sig_q, sig_d;
  logic             mismatch_q, mismatch_d;
  pipe_ent_t        pipe_q [LATENCY];
  pipe_ent_t        pipe_d [LATENCY];

  logic [WIDTH-1:0] ref_r;
  logic             ref_zero;
  logic             ref_ovf;
  logic             accept;
  pipe_ent_t        head;
  logic             cmp_fire;
  logic             cmp_bad;
  logic [WIDTH-1:0] misr_next;

  // Reference ALU: wrap-around result, signed overflow only for ADD/SUB
  always_comb begin
    ref_r   = '0;
    ref_ovf = 1'b0;
    case (ctrl)
      2'b00: begin
        ref_r   = a + b;
        ref_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (ref_r[WIDTH-1] != a[WIDTH-1]);
      end
      2'b01: begin
        ref_r   = a - b;
        ref_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (ref_r[WIDTH-1] != a[WIDTH-1]);
      end
      2'b10:   ref_r = a & b;
      default: ref_r = a | b;
    endcase
    ref_zero = (ref_r == '0);
  end

  assign accept   = (state_q == RUN) && in_valid && (accepted_q < NUM_VEC);
  assign head     = pipe_q[LATENCY-1];
  assign cmp_fire = (state_q == RUN) && head.vld;
  assign cmp_bad  = cmp_fire && ({r, zero, ovf} != {head.r, head.zero, head.ovf});

  assign misr_next = {sig_q[WIDTH-2:0], 1'b0}
                   ^ (sig_q[WIDTH-1] ? POLY : '0)
                   ^ r
                   ^ {{(WIDTH-2){1'b0}}, ovf, zero};

  // Alignment pipe: never stalls, one slot per cycle of ALU latency
  always_comb begin
    pipe_d[0].vld  = accept;
    pipe_d[0].r    = ref_r;
    pipe_d[0].zero = ref_zero;
    pipe_d[0].ovf  = ref_ovf;
    pipe_d[0].idx  = accepted_q;
    for (int i = 1; i < LATENCY; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  // Run control and result bookkeeping
  always_comb begin
    state_d    = state_q;
    accepted_d = accepted_q;
    compared_d = compared_q;
    err_d      = err_q;
    fev_d      = fev_q;
    fei_d      = fei_q;
    sig_d      = sig_q;
    mismatch_d = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = RUN;
          accepted_d = '0;
          compared_d = '0;
          err_d      = '0;
          fev_d      = 1'b0;
          fei_d      = '0;
          sig_d      = '0;
        end
      end
      RUN: begin
        if (accept) begin
          accepted_d = accepted_q + CNT_W'(1);
        end
        if (cmp_fire) begin
          compared_d = compared_q + CNT_W'(1);
          sig_d      = misr_next;
          if (cmp_bad) begin
            mismatch_d = 1'b1;
            if (err_q != '1) begin
              err_d = err_q + ERR_W'(1);
            end
            if (!fev_q) begin
              fev_d = 1'b1;
              fei_d = head.idx;
            end
          end
          // Final compare ends the run; a simultaneous start is ignored
          if (compared_q == LAST_IDX) begin
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      accepted_q <= '0;
      compared_q <= '0;
      err_q      <= '0;
      fev_q      <= 1'b0;
      fei_q      <= '0;
      sig_q      <= '0;
      mismatch_q <= 1'b0;
      for (int i = 0; i < LATENCY; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      accepted_q <= accepted_d;
      compared_q <= compared_d;
      err_q      <= err_d;
      fev_q      <= fev_d;
      fei_q      <= fei_d;
      sig_q      <= sig_d;
      mismatch_q <= mismatch_d;
      pipe_q     <= pipe_d;
    end
  end

  assign busy            = (state_q == RUN);
  assign done            = (state_q == DONE);
  assign pass            = (state_q == DONE) && (err_q == '0);
  assign mismatch        = mismatch_q;
  assign err_count       = err_q;
  assign first_err_valid = fev_q;
  assign first_err_idx   = fei_q;
  assign signature       = sig_q;

endmodule

// File: tb/tb_alu_response_checker.sv
// Randomized scoreboard bench: an ALU stand-in replays per-vector responses with fixed latency while a
// queue of expected run results and mismatch events is checked by an independent monitor.
module tb_alu_response_checker;

  localparam int unsigned W   = 32;
  localparam int unsigned LAT = 2;
  localparam int unsigned NV  = 8;
  localparam int unsigned CW  = 4;
  localparam int unsigned EW  = 2;
  localparam logic [31:0] POLY = 32'h04C11DB7;

  logic          clk, reset, start, in_valid;
  logic [W-1:0]  a, b, r;
  logic [1:0]    ctrl;
  logic          zero, ovf;
  logic          busy, done, pass, mismatch, first_err_valid;
  logic [EW-1:0] err_count;
  logic [CW-1:0] first_err_idx;
  logic [W-1:0]  signature;

  alu_response_checker #(
    .WIDTH(W), .LATENCY(LAT), .NUM_VECTORS(NV), .CNT_W(CW), .ERR_W(EW), .POLY(POLY)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .a(a), .b(b), .ctrl(ctrl), .r(r), .zero(zero), .ovf(ovf),
    .busy(busy), .done(done), .pass(pass), .mismatch(mismatch),
    .err_count(err_count), .first_err_valid(first_err_valid),
    .first_err_idx(first_err_idx), .signature(signature)
  );

  typedef struct {
    logic [EW-1:0] err;
    logic          fv;
    logic [CW-1:0] fi;
    logic [W-1:0]  sig;
    logic          pass;
    int            npulse;
  } sum_t;

  sum_t          sum_q[$];
  logic [EW-1:0] mm_q[$];
  logic [31:0]   va [NV];
  logic [31:0]   vb [NV];
  logic [1:0]    vc [NV];
  logic [33:0]   vexp [NV];
  logic [33:0]   vresp [NV];
  logic [33:0]   resp_drv;
  logic [33:0]   alu_pipe [LAT];
  int            n_chk, n_pass, pulses;
  bit            mon_off;
  logic          done_prev;
  sum_t          s_mon;
  logic [EW-1:0] e_mon;
  logic [31:0]   sig_a, sig_b, sig_c;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU stand-in: replays the response chosen for each vector LAT cycles later
  always @(posedge clk) begin
    alu_pipe[0] <= resp_drv;
    for (int i = 1; i < LAT; i++) alu_pipe[i] <= alu_pipe[i-1];
  end
  assign {r, zero, ovf} = alu_pipe[LAT-1];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    else n_pass++;
  endtask

  function automatic logic [33:0] ref_alu(input logic [31:0] x, input logic [31:0] y,
                                          input logic [1:0] op);
    longint sx, sy, res;
    logic [31:0] rr;
    logic o;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (op)
      2'd0:    res = sx + sy;
      2'd1:    res = sx - sy;
      2'd2:    res = longint'(x & y);
      default: res = longint'(x | y);
    endcase
    o  = (op < 2'd2) && (res > 64'sd2147483647 || res < -64'sd2147483648);
    rr = res[31:0];
    return {rr, (rr == 32'd0), o};
  endfunction

  function automatic logic [31:0] misr(input logic [31:0] s, input logic [33:0] rsp);
    logic [31:0] n;
    n = s << 1;
    if (s[31]) n = n ^ POLY;
    n = n ^ rsp[33:2] ^ {30'd0, rsp[0], rsp[1]};
    return n;
  endfunction

  // mode 0 golden, 1 r[0] stuck-1 on vector 2, 2 every vector wrong, 3 random faults
  task automatic gen_random(input int mode);
    for (int i = 0; i < NV; i++) begin
      va[i] = $urandom;
      vb[i] = ($urandom_range(0, 4) == 0) ? va[i] : $urandom;
      vc[i] = 2'($urandom_range(0, 3));
      if (mode == 1 && i == 2) begin
        va[i][0] = 1'b0;
        vb[i][0] = 1'b0;
        vc[i]    = 2'd0;
      end
      vexp[i]  = ref_alu(va[i], vb[i], vc[i]);
      vresp[i] = vexp[i];
      if (mode == 1 && i == 2) vresp[i] = vexp[i] | 34'h4;
      if (mode == 2 || (mode == 3 && $urandom_range(0, 3) == 0))
        vresp[i] = vexp[i] ^ (34'd1 << $urandom_range(0, 33));
    end
  endtask

  // Must be called at a negedge; returns at the negedge where done first shows
  task automatic do_run(input bit late_start, input bit linger, output logic [31:0] msig);
    sum_t s;
    int i;
    s.err = '0; s.fv = 1'b0; s.fi = '0; s.sig = '0; s.npulse = 0;
    for (int k = 0; k < NV; k++) begin
      s.sig = misr(s.sig, vresp[k]);
      if (vresp[k] !== vexp[k]) begin
        s.npulse++;
        if (s.err != '1) s.err = s.err + EW'(1);
        mm_q.push_back(s.err);
        if (!s.fv) begin s.fv = 1'b1; s.fi = CW'(k); end
      end
    end
    s.pass = (s.npulse == 0);
    sum_q.push_back(s);
    msig = s.sig;

    start = 1'b1; in_valid = 1'b1; a = $urandom; b = $urandom; resp_drv = {$urandom, 2'b00};
    @(negedge clk);
    start = 1'b0;
    i = 0;
    while (i < NV) begin
      if (i > 0 && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0; start = 1'b0;
      end else begin
        in_valid = 1'b1; a = va[i]; b = vb[i]; ctrl = vc[i]; resp_drv = vresp[i];
        start = (i == 3);
        i++;
      end
      @(negedge clk);
    end
    for (int k = 1; k <= LAT; k++) begin
      if (k == LAT) begin
        chk("busy_before_last_compare", 64'(busy), 64'd1);
        chk("done_before_last_compare", 64'(done), 64'd0);
      end
      in_valid = 1'b1; a = $urandom; b = $urandom; ctrl = 2'($urandom_range(0, 3));
      resp_drv = {$urandom, 2'b01};
      start = (k == LAT) && late_start;
      @(negedge clk);
    end
    in_valid = 1'b0; start = 1'b0;
    chk("done_after_last_compare", 64'(done), 64'd1);
    chk("busy_after_last_compare", 64'(busy), 64'd0);
    if (linger) begin
      repeat (3) @(negedge clk);
      chk("done_held", 64'(done), 64'd1);
      chk("err_count_held", 64'(err_count), 64'(s.err));
      chk("signature_held", 64'(signature), 64'(s.sig));
    end
  endtask

  // Monitor: pops expectations on each mismatch pulse and on each rising done
  always @(negedge clk) begin
    if (reset) begin
      done_prev = 1'b0;
      pulses    = 0;
    end else if (!mon_off) begin
      if (mismatch) begin
        pulses++;
        chk("mismatch_expected", 64'(mm_q.size() != 0), 64'd1);
        if (mm_q.size() != 0) begin
          e_mon = mm_q.pop_front();
          chk("err_count_at_mismatch", 64'(err_count), 64'(e_mon));
        end
      end
      if (done && !done_prev) begin
        chk("run_expected", 64'(sum_q.size() != 0), 64'd1);
        if (sum_q.size() != 0) begin
          s_mon = sum_q.pop_front();
          chk("mismatch_pulses", 64'(pulses), 64'(s_mon.npulse));
          chk("err_count", 64'(err_count), 64'(s_mon.err));
          chk("first_err_valid", 64'(first_err_valid), 64'(s_mon.fv));
          chk("first_err_idx", 64'(first_err_idx), 64'(s_mon.fi));
          chk("signature", 64'(signature), 64'(s_mon.sig));
          chk("pass", 64'(pass), 64'(s_mon.pass));
        end
        pulses = 0;
      end
      done_prev = done;
    end
  end

  initial begin
    n_chk = 0; n_pass = 0; mon_off = 1'b0;
    reset = 1'b1; start = 1'b0; in_valid = 1'b0;
    a = '0; b = '0; ctrl = '0; resp_drv = '0;
    alu_pipe[0] = '0; alu_pipe[1] = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_pass", 64'(pass), 64'd0);
    chk("rst_mismatch", 64'(mismatch), 64'd0);
    chk("rst_err_count", 64'(err_count), 64'd0);
    chk("rst_first_err_valid", 64'(first_err_valid), 64'd0);
    chk("rst_first_err_idx", 64'(first_err_idx), 64'd0);
    chk("rst_signature", 64'(signature), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed: basic ops and overflow/zero boundaries with hand-computed ALU responses
    va[0] = 32'd5;        vb[0] = 32'd3;        vc[0] = 2'd0; vexp[0] = {32'h8, 2'b00};
    va[1] = 32'd5;        vb[1] = 32'd3;        vc[1] = 2'd1; vexp[1] = {32'h2, 2'b00};
    va[2] = 32'hF0;       vb[2] = 32'h3C;       vc[2] = 2'd2; vexp[2] = {32'h30, 2'b00};
    va[3] = 32'hF0;       vb[3] = 32'h3C;       vc[3] = 2'd3; vexp[3] = {32'hFC, 2'b00};
    va[4] = 32'h7FFFFFFF; vb[4] = 32'd1;        vc[4] = 2'd0; vexp[4] = {32'h80000000, 2'b01};
    va[5] = 32'h80000000; vb[5] = 32'd1;        vc[5] = 2'd1; vexp[5] = {32'h7FFFFFFF, 2'b01};
    va[6] = 32'd3;        vb[6] = 32'd3;        vc[6] = 2'd1; vexp[6] = {32'h0, 2'b10};
    va[7] = 32'hFFFFFFFF; vb[7] = 32'd1;        vc[7] = 2'd0; vexp[7] = {32'h0, 2'b10};
    for (int i = 0; i < NV; i++) vresp[i] = vexp[i];
    do_run(1'b0, 1'b0, sig_a);

    gen_random(1);
    do_run(1'b0, 1'b1, sig_a);
    gen_random(2);
    do_run(1'b1, 1'b0, sig_a);

    gen_random(0);
    do_run(1'b0, 1'b0, sig_a);
    do_run(1'b0, 1'b1, sig_b);
    vresp[5] = vresp[5] ^ 34'h400;
    do_run(1'b0, 1'b0, sig_c);
    chk("signature_changed_by_flip", 64'(signature != sig_a), 64'd1);

    // Reset with vectors in flight
    gen_random(2);
    mon_off = 1'b1;
    start = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; a = va[i]; b = vb[i]; ctrl = vc[i]; resp_drv = vresp[i];
      @(negedge clk);
    end
    chk("pre_reset_err_count", 64'(err_count), 64'd3);
    chk("pre_reset_busy", 64'(busy), 64'd1);
    reset = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    chk("midrun_rst_busy", 64'(busy), 64'd0);
    chk("midrun_rst_done", 64'(done), 64'd0);
    chk("midrun_rst_err_count", 64'(err_count), 64'd0);
    chk("midrun_rst_first_err_valid", 64'(first_err_valid), 64'd0);
    chk("midrun_rst_first_err_idx", 64'(first_err_idx), 64'd0);
    chk("midrun_rst_signature", 64'(signature), 64'd0);
    chk("midrun_rst_mismatch", 64'(mismatch), 64'd0);
    reset = 1'b0;
    mm_q.delete();
    sum_q.delete();
    mon_off = 1'b0;
    @(negedge clk);

    for (int n = 0; n < 4; n++) begin
      gen_random(3);
      do_run(n[0], n[1], sig_a);
    end
    repeat (3) @(negedge clk);
    chk("leftover_runs", 64'(sum_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
